conv_ctrl_gen: RTL and testbench

- Parametrised control sequencer for one convolution layer. Generates M9K read/write enables, address-generator enables, MAC sload/enable/clear, and the input-feature channel-group mux.
- Channel-group count is set at run time, with a start/done handshake, abort, and latency-aligned select/sload/valid.
- Sits between the layer's feature/weight memories and the MAC array. One instance per conv layer.

---
 rtl/conv_ctrl_gen_if.sv | 49 ++++
 rtl/conv_ctrl_gen.sv | 185 ++++++++++++++++++
 tb/tb_conv_ctrl_gen.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/conv_ctrl_gen_if.sv
// Bundle of control, configuration and feature-data signals between a conv-layer
// sequencer (slave) and the logic that drives it (master).
interface conv_ctrl_gen_if #(
    parameter int DATA_WIDTH        = 8,
    parameter int INPUT_NUM_MEM     = 16,
    parameter int IFMAP_PAR         = 1,
    parameter int OUT_FEATURE_WIDTH = 10,
    parameter int NUM_ONEMULT       = 1
);
    localparam int MAX_GROUPS = INPUT_NUM_MEM / IFMAP_PAR;
    localparam int GRP_W      = (MAX_GROUPS > 1) ? $clog2(MAX_GROUPS) : 1;
    localparam int TOTAL      = OUT_FEATURE_WIDTH * OUT_FEATURE_WIDTH * NUM_ONEMULT;
    localparam int PIX_W      = $clog2(TOTAL + 1);

    logic                                start;
    logic                                abort;
    logic [GRP_W:0]                      cfg_num_groups;
    logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_a_all;
    logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_b_all;
    logic [DATA_WIDTH*IFMAP_PAR-1:0]     in_feature_q_a_mux_all;
    logic [DATA_WIDTH*IFMAP_PAR-1:0]     in_feature_q_b_mux_all;
    logic                                in_feature_rden;
    logic                                weight_rden;
    logic                                in_feature_wren;
    logic                                weight_wren;
    logic                                enable_addrger;
    logic                                enable_weightaddrger;
    logic                                enable_mult;
    logic                                clear_mult;
    logic                                accum_sload;
    logic                                out_valid;
    logic                                busy;
    logic                                done;
    logic [PIX_W-1:0]                    pix_count;

    modport master (
        output start, abort, cfg_num_groups, in_feature_q_a_all, in_feature_q_b_all,
        input  in_feature_q_a_mux_all, in_feature_q_b_mux_all, in_feature_rden, weight_rden,
               in_feature_wren, weight_wren, enable_addrger, enable_weightaddrger,
               enable_mult, clear_mult, accum_sload, out_valid, busy, done, pix_count
    );

    modport slave (
        input  start, abort, cfg_num_groups, in_feature_q_a_all, in_feature_q_b_all,
        output in_feature_q_a_mux_all, in_feature_q_b_mux_all, in_feature_rden, weight_rden,
               in_feature_wren, weight_wren, enable_addrger, enable_weightaddrger,
               enable_mult, clear_mult, accum_sload, out_valid, busy, done, pix_count
    );
endinterface

// File: rtl/conv_ctrl_gen.sv
// Control sequencer for one convolution layer: walks cycle/group/pixel counters,
// drives memory and MAC enables, and muxes the active channel group into the MAC.
module conv_ctrl_gen #(
    parameter int DATA_WIDTH        = 8,
    parameter int INPUT_NUM_MEM     = 16,
    parameter int IFMAP_PAR         = 1,
    parameter int MAX_GROUPS        = INPUT_NUM_MEM / IFMAP_PAR,
    parameter int PIXEL_CYCLE_INTER = 25,
    parameter int OUT_FEATURE_WIDTH = 10,
    parameter int NUM_ONEMULT       = 1,
    parameter int RD_LAT            = 2,
    parameter int MAC_LAT           = 2
) (
    input logic            clock,
    input logic            reset,
    conv_ctrl_gen_if.slave bus
);
    localparam int GRP_W = (MAX_GROUPS > 1) ? $clog2(MAX_GROUPS) : 1;
    localparam int CYC_W = (PIXEL_CYCLE_INTER > 1) ? $clog2(PIXEL_CYCLE_INTER) : 1;
    localparam int TOTAL = OUT_FEATURE_WIDTH * OUT_FEATURE_WIDTH * NUM_ONEMULT;
    localparam int PIX_W = $clog2(TOTAL + 1);
    localparam int V_LAT = RD_LAT + MAC_LAT;
    localparam int DRN_W = (V_LAT > 1) ? $clog2(V_LAT) : 1;
    localparam int MEM_W = (INPUT_NUM_MEM > 1) ? $clog2(INPUT_NUM_MEM) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(PIXEL_CYCLE_INTER - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(TOTAL - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(V_LAT - 1);
    localparam logic [GRP_W:0]   G_MAX    = (GRP_W + 1)'(MAX_GROUPS);

    logic [1:0]       state_reg;
    logic [CYC_W-1:0] cyc_reg;
    logic [GRP_W-1:0] grp_reg;
    logic [GRP_W-1:0] g_last_reg;
    logic [PIX_W-1:0] pix_reg;
    logic [DRN_W-1:0] drn_reg;

    logic [RD_LAT-1:0] sload_pipe_reg;
    logic [RD_LAT-1:0] run_pipe_reg;
    logic [GRP_W-1:0]  sel_pipe_reg [RD_LAT];
    logic [V_LAT-1:0]  valid_pipe_reg;

    logic             idle_st;
    logic             run_st;
    logic             drain_st;
    logic             abort_hit;
    logic             sload_raw;
    logic             last_raw;
    logic [GRP_W:0]   g_clamped;
    logic [GRP_W-1:0] sel;
    logic             run_d;

    assign idle_st   = (state_reg == S_IDLE);
    assign run_st    = (state_reg == S_RUN);
    assign drain_st  = (state_reg == S_DRAIN);
    assign abort_hit = bus.abort && !idle_st;
    assign sload_raw = run_st && (cyc_reg == '0) && (grp_reg == '0);
    assign last_raw  = run_st && (cyc_reg == CYC_LAST) && (grp_reg == g_last_reg);

    // Zero groups would never finish a pixel, so it runs as a single group.
    always_comb begin
        g_clamped = bus.cfg_num_groups;
        if (bus.cfg_num_groups == '0)
            g_clamped = (GRP_W + 1)'(1);
        else if (bus.cfg_num_groups > G_MAX)
            g_clamped = G_MAX;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= S_IDLE;
            cyc_reg    <= '0;
            grp_reg    <= '0;
            g_last_reg <= '0;
            pix_reg    <= '0;
            drn_reg    <= '0;
        end else if (abort_hit) begin
            state_reg <= S_IDLE;
            cyc_reg   <= '0;
            grp_reg   <= '0;
            drn_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        state_reg  <= S_RUN;
                        g_last_reg <= GRP_W'(g_clamped - (GRP_W + 1)'(1));
                        cyc_reg    <= '0;
                        grp_reg    <= '0;
                        pix_reg    <= '0;
                    end
                end
                S_RUN: begin
                    if (cyc_reg == CYC_LAST) begin
                        cyc_reg <= '0;
                        if (grp_reg == g_last_reg) begin
                            grp_reg <= '0;
                            pix_reg <= pix_reg + 1'b1;
                            if (pix_reg == PIX_LAST) begin
                                state_reg <= S_DRAIN;
                                drn_reg   <= '0;
                            end
                        end else begin
                            grp_reg <= grp_reg + 1'b1;
                        end
                    end else begin
                        cyc_reg <= cyc_reg + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drn_reg == DRN_LAST)
                        state_reg <= S_DONE;
                    else
                        drn_reg <= drn_reg + 1'b1;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Delay lines align select/sload with memory read data and valid with MAC output.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sload_pipe_reg <= '0;
            run_pipe_reg   <= '0;
            valid_pipe_reg <= '0;
            for (int i = 0; i < RD_LAT; i++) sel_pipe_reg[i] <= '0;
        end else if (abort_hit) begin
            sload_pipe_reg <= '0;
            run_pipe_reg   <= '0;
            valid_pipe_reg <= '0;
            for (int i = 0; i < RD_LAT; i++) sel_pipe_reg[i] <= '0;
        end else begin
            sload_pipe_reg[0] <= sload_raw;
            run_pipe_reg[0]   <= run_st;
            sel_pipe_reg[0]   <= grp_reg;
            valid_pipe_reg[0] <= last_raw;
            for (int i = 1; i < RD_LAT; i++) begin
                sload_pipe_reg[i] <= sload_pipe_reg[i-1];
                run_pipe_reg[i]   <= run_pipe_reg[i-1];
                sel_pipe_reg[i]   <= sel_pipe_reg[i-1];
            end
            for (int i = 1; i < V_LAT; i++) valid_pipe_reg[i] <= valid_pipe_reg[i-1];
        end
    end

    assign sel   = sel_pipe_reg[RD_LAT-1];
    assign run_d = run_pipe_reg[RD_LAT-1];

    logic [DATA_WIDTH-1:0] q_a_words [INPUT_NUM_MEM];
    logic [DATA_WIDTH-1:0] q_b_words [INPUT_NUM_MEM];

    genvar gi;
    generate
        for (gi = 0; gi < INPUT_NUM_MEM; gi++) begin : g_unpack
            assign q_a_words[gi] = bus.in_feature_q_a_all[gi*DATA_WIDTH +: DATA_WIDTH];
            assign q_b_words[gi] = bus.in_feature_q_b_all[gi*DATA_WIDTH +: DATA_WIDTH];
        end
        for (gi = 0; gi < IFMAP_PAR; gi++) begin : g_mux
            logic [MEM_W-1:0] idx;
            assign idx = MEM_W'(sel * IFMAP_PAR + gi);
            assign bus.in_feature_q_a_mux_all[gi*DATA_WIDTH +: DATA_WIDTH] = run_d ? q_a_words[idx] : '0;
            assign bus.in_feature_q_b_mux_all[gi*DATA_WIDTH +: DATA_WIDTH] = run_d ? q_b_words[idx] : '0;
        end
    endgenerate

    assign bus.in_feature_rden      = run_st;
    assign bus.weight_rden          = run_st;
    assign bus.enable_addrger       = run_st;
    assign bus.enable_weightaddrger = run_st;
    assign bus.enable_mult          = run_st || drain_st;
    assign bus.clear_mult           = idle_st && bus.start;
    assign bus.in_feature_wren      = 1'b0;
    assign bus.weight_wren          = 1'b0;
    assign bus.accum_sload          = sload_pipe_reg[RD_LAT-1];
    assign bus.out_valid            = valid_pipe_reg[V_LAT-1];
    assign bus.busy                 = !idle_st;
    assign bus.done                 = (state_reg == S_DONE);
    assign bus.pix_count            = pix_reg;
endmodule

// File: tb/tb_conv_ctrl_gen.sv
// Directed checks of conv_ctrl_gen: a default-size instance for full-length timing,
// abort and async reset, and a 2x2/3-cycle instance for per-cycle sload/mux/valid.
module tb_conv_ctrl_gen;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    conv_ctrl_gen_if #(.DATA_WIDTH(8), .INPUT_NUM_MEM(16), .IFMAP_PAR(1),
                       .OUT_FEATURE_WIDTH(10), .NUM_ONEMULT(1)) bus ();
    conv_ctrl_gen_if #(.DATA_WIDTH(8), .INPUT_NUM_MEM(16), .IFMAP_PAR(1),
                       .OUT_FEATURE_WIDTH(2), .NUM_ONEMULT(1)) bus_s ();

    conv_ctrl_gen dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    conv_ctrl_gen #(.PIXEL_CYCLE_INTER(3), .OUT_FEATURE_WIDTH(2)) dut_s (
        .clock (clock),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // One run of the small instance: 4 pixels of g groups x 3 cycles.
    task automatic run_small(input logic [4:0] cfg, input int g, input bit hold);
        int p = 3 * g;
        logic [7:0] ea;
        logic [7:0] eb;
        @(negedge clock);
        bus_s.cfg_num_groups = cfg;
        bus_s.start = 1'b1;
        #1;
        chk("s_clear_mult", bus_s.clear_mult, 1);
        chk("s_busy_t0", bus_s.busy, 0);
        for (int k = 1; k <= 4*p + 6; k++) begin
            @(negedge clock);
            if (!hold || k > 2*p) bus_s.start = 1'b0;
            #1;
            if (k >= 3 && k <= 4*p + 2) begin
                ea = 8'(8'h30 + ((k - 3) / 3) % g);
                eb = 8'(8'hC0 + ((k - 3) / 3) % g);
            end else begin
                ea = 8'h00;
                eb = 8'h00;
            end
            if (k == 1) chk("s_pix_restart", bus_s.pix_count, 0);
            chk("s_busy", bus_s.busy, k <= 4*p + 5);
            chk("s_done", bus_s.done, k == 4*p + 5);
            chk("s_rden", bus_s.in_feature_rden, k <= 4*p);
            chk("s_mult", bus_s.enable_mult, k <= 4*p + 4);
            chk("s_sload", bus_s.accum_sload, k >= 3 && k <= 4*p + 2 && (k - 3) % p == 0);
            chk("s_valid", bus_s.out_valid, k - 4 >= p && k - 4 <= 4*p && (k - 4) % p == 0);
            chk("s_mux_a", bus_s.in_feature_q_a_mux_all, ea);
            chk("s_mux_b", bus_s.in_feature_q_b_mux_all, eb);
        end
        chk("s_pix_final", bus_s.pix_count, 4);
        $display("small run cfg=%0d G=%0d hold=%0d complete", cfg, g, hold);
    endtask

    initial begin
        int first_ov, ov_cnt, done_at, done_cnt, rd_cnt, sl_cnt, first_sl;
        bus.start = 1'b0;   bus.abort = 1'b0;   bus.cfg_num_groups = '0;
        bus_s.start = 1'b0; bus_s.abort = 1'b0; bus_s.cfg_num_groups = '0;
        for (int i = 0; i < 16; i++) begin
            bus.in_feature_q_a_all[i*8 +: 8]   = 8'(8'h30 + i);
            bus.in_feature_q_b_all[i*8 +: 8]   = 8'(8'hC0 + i);
            bus_s.in_feature_q_a_all[i*8 +: 8] = 8'(8'h30 + i);
            bus_s.in_feature_q_b_all[i*8 +: 8] = 8'(8'hC0 + i);
        end

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rden", bus.in_feature_rden, 0);
        chk("rst_mult", bus.enable_mult, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_sload", bus.accum_sload, 0);
        chk("rst_mux", bus.in_feature_q_a_mux_all, 0);
        chk("rst_pix", bus.pix_count, 0);
        chk("rst_wren", {bus.in_feature_wren, bus.weight_wren}, 0);
        reset = 1'b1;
        $display("reset released");

        // Small instance: G=2, start held for part of the run, then a fresh rerun, then G=1 and clamp
        run_small(5'd2, 2, 1'b0);
        repeat (3) @(negedge clock);
        chk("s_pix_hold", bus_s.pix_count, 4);
        run_small(5'd2, 2, 1'b1);
        run_small(5'd0, 1, 1'b0);
        run_small(5'd31, 16, 1'b0);

        // Abort at t0+100 on the default instance
        @(negedge clock);
        bus.cfg_num_groups = 5'd16;
        bus.start = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock);
            bus.start = 1'b0;
        end
        #1;
        chk("abort_pre_mux", bus.in_feature_q_a_mux_all, 8'h33);
        chk("abort_pre_busy", bus.busy, 1);
        bus.abort = 1'b1;
        @(negedge clock);
        bus.abort = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_rden", bus.in_feature_rden, 0);
        chk("abort_mult", bus.enable_mult, 0);
        chk("abort_mux", bus.in_feature_q_a_mux_all, 0);
        chk("abort_sload", bus.accum_sload, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk("abort_done", bus.done, 0);
            chk("abort_valid", bus.out_valid, 0);
            chk("abort_mux_hold", bus.in_feature_q_b_mux_all, 0);
        end
        $display("abort sequence complete");

        // Asynchronous reset mid-run at t0+50
        @(negedge clock);
        bus.start = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clock);
            bus.start = 1'b0;
        end
        #1;
        chk("arst_pre_mux", bus.in_feature_q_a_mux_all, 8'h31);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_rden", bus.in_feature_rden, 0);
        chk("arst_mult", bus.enable_mult, 0);
        chk("arst_mux", bus.in_feature_q_a_mux_all, 0);
        chk("arst_valid", bus.out_valid, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        chk("arst_idle_busy", bus.busy, 0);
        chk("arst_idle_rden", bus.in_feature_rden, 0);
        $display("async reset sequence complete");

        // Full default-size run with cfg=31, clamped to 16 groups
        @(negedge clock);
        bus.cfg_num_groups = 5'd31;
        bus.start = 1'b1;
        #1;
        chk("full_clear_mult", bus.clear_mult, 1);
        first_ov = -1; ov_cnt = 0; done_at = -1; done_cnt = 0;
        rd_cnt = 0; sl_cnt = 0; first_sl = -1;
        for (int k = 1; k <= 40010; k++) begin
            @(negedge clock);
            bus.start = 1'b0;
            #1;
            if (bus.out_valid) begin ov_cnt++; if (first_ov < 0) first_ov = k; end
            if (bus.accum_sload) begin sl_cnt++; if (first_sl < 0) first_sl = k; end
            if (bus.done) begin done_cnt++; if (done_at < 0) done_at = k; end
            if (bus.in_feature_rden) rd_cnt++;
            if (k == 1) chk("full_busy_rise", bus.busy, 1);
            if (k == 40000) chk("full_rden_last", bus.in_feature_rden, 1);
            if (k == 40001) chk("full_rden_drain", bus.in_feature_rden, 0);
            if (k == 40004) chk("full_mult_drain", bus.enable_mult, 1);
            if (k == 40005) chk("full_busy_done", bus.busy, 1);
            if (k == 40005) chk("full_mult_done", bus.enable_mult, 0);
            if (k == 40006) chk("full_busy_fall", bus.busy, 0);
        end
        chk("full_first_valid", 64'(first_ov), 64'(404));
        chk("full_valid_count", 64'(ov_cnt), 64'(100));
        chk("full_first_sload", 64'(first_sl), 64'(3));
        chk("full_sload_count", 64'(sl_cnt), 64'(100));
        chk("full_done_at", 64'(done_at), 64'(40005));
        chk("full_done_count", 64'(done_cnt), 64'(1));
        chk("full_rden_count", 64'(rd_cnt), 64'(40000));
        chk("full_pix_final", bus.pix_count, 100);
        $display("full run complete: valid=%0d done_at=%0d", ov_cnt, done_at);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
